// File: rtl/i2c_pkg.sv
// i2c_pkg: controller state encoding, I2C direction constants and default write-cycle time
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, SETUP, XFER_START, XFER, XFER_WAIT, TWR_WAIT, RD_START, RD_XFER, FINISH
  } state_t;
  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam int TWR_CYCLES_DEFAULT = 250000;
endpackage

// File: rtl/eeprom_page_calc.sv
// eeprom_page_calc: bytes that can be written before crossing the next page boundary
module eeprom_page_calc #(
  parameter int PAGE_SIZE = 64
) (
  input  logic [15:0] addr,
  input  logic [7:0]  remaining,
  output logic [7:0]  seg_len
);
  logic [16:0] room;
  assign room = 17'(PAGE_SIZE) - 17'(addr & 16'(PAGE_SIZE - 1));
  assign seg_len = (17'(remaining) < room) ? remaining : room[7:0];
endmodule

// File: rtl/i2c_eeprom_ctrl.sv
// i2c_eeprom_ctrl: page-aware EEPROM read/write sequencer driving a byte-level I2C master
module i2c_eeprom_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int PAGE_SIZE  = 64,
  parameter int MAX_NBYTES = 255,
  parameter int TWR_CYCLES = TWR_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_slave_addr,
  input  logic [15:0] cmd_mem_addr,
  input  logic [7:0]  cmd_nbytes,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        error,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_nbytes,
  output logic [7:0]  i2c_write_data,
  input  logic [7:0]  i2c_read_data,
  input  logic        i2c_tx_data_req,
  input  logic        i2c_rx_data_ready,
  input  logic        i2c_ready,
  input  logic        i2c_busy
);
  localparam logic [15:0] ADDR_MASK = ADDR_BYTES == 1 ? 16'h00FF : 16'hFFFF;
  state_t state, state_nx;
  logic rw, pending, err, busy_d, busy_fall, last_twr, data_req, bad_cmd;
  logic [15:0] addr;
  logic [7:0] nbytes, remaining, seg_len, seg_calc;
  logic [8:0] idx, nxt, total;
  logic [31:0] twr_cnt;
  eeprom_page_calc #(.PAGE_SIZE(PAGE_SIZE)) u_page_calc (
    .addr(addr),
    .remaining(remaining),
    .seg_len(seg_calc)
  );
  assign bad_cmd = cmd_nbytes == '0 || 32'(cmd_nbytes) > 32'(MAX_NBYTES);
  assign total = 9'(ADDR_BYTES) + {1'b0, seg_len};
  assign nxt = idx + 9'd1;
  assign busy_fall = busy_d && !i2c_busy;
  assign last_twr = twr_cnt == 32'(TWR_CYCLES - 1);
  // a request whose following byte is payload must pull it from the write stream
  assign data_req = i2c_tx_data_req && nxt >= 9'(ADDR_BYTES) && nxt < total;
  assign cmd_ready = state == IDLE;
  assign wr_ready = state == XFER && (pending || data_req);
  assign i2c_start = (state == XFER_START || state == RD_START) && i2c_ready;
  assign done = state == FINISH;
  assign error = done && err;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (cmd_valid) state_nx = bad_cmd ? FINISH : SETUP;
      SETUP:      state_nx = XFER_START;
      XFER_START: if (i2c_ready) state_nx = XFER;
      XFER:       if (busy_fall) state_nx = XFER_WAIT;
      XFER_WAIT:  state_nx = rw ? RD_START : TWR_WAIT;
      TWR_WAIT:   if (last_twr) state_nx = remaining == seg_len ? FINISH : SETUP;
      RD_START:   if (i2c_ready) state_nx = RD_XFER;
      RD_XFER:    if (busy_fall) state_nx = FINISH;
      FINISH:     state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rw <= 1'b0;
      pending <= 1'b0;
      err <= 1'b0;
      busy_d <= 1'b0;
      addr <= '0;
      nbytes <= '0;
      remaining <= '0;
      seg_len <= '0;
      idx <= '0;
      twr_cnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      i2c_addr <= '0;
      i2c_rw <= I2C_RW_WRITE;
      i2c_nbytes <= '0;
      i2c_write_data <= '0;
    end else begin
      busy_d <= i2c_busy;
      rd_valid <= state == RD_XFER && i2c_rx_data_ready;
      if (state == RD_XFER && i2c_rx_data_ready) rd_data <= i2c_read_data;
      case (state)
        IDLE: if (cmd_valid) begin
          rw <= cmd_rw;
          i2c_addr <= cmd_slave_addr;
          addr <= cmd_mem_addr & ADDR_MASK;
          nbytes <= cmd_nbytes;
          remaining <= cmd_nbytes;
          err <= bad_cmd;
        end
        SETUP: begin
          seg_len <= rw ? 8'd0 : seg_calc;
          idx <= '0;
          pending <= 1'b0;
          twr_cnt <= '0;
          i2c_rw <= I2C_RW_WRITE;
          i2c_nbytes <= 8'(ADDR_BYTES) + (rw ? 8'd0 : seg_calc);
          i2c_write_data <= ADDR_BYTES == 2 ? addr[15:8] : addr[7:0];
        end
        XFER: if (pending || data_req) begin
          if (wr_valid) begin
            i2c_write_data <= wr_data;
            idx <= nxt;
            pending <= 1'b0;
          end else begin
            pending <= 1'b1;
            err <= 1'b1;
          end
        end else if (i2c_tx_data_req) begin
          idx <= nxt;
          i2c_write_data <= addr[7:0];
        end
        XFER_WAIT: if (rw) begin
          i2c_rw <= I2C_RW_READ;
          i2c_nbytes <= nbytes;
        end
        TWR_WAIT: begin
          twr_cnt <= twr_cnt + 32'd1;
          if (last_twr) begin
            addr <= (addr + 16'(seg_len)) & ADDR_MASK;
            remaining <= remaining - seg_len;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
